// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: request/response bundle for the pipelined selector.
//   in_bus    : N_INPUTS flattened WIDTH-bit data inputs (input k at [k*WIDTH +: WIDTH])
//   sel       : input select, meaningful while in_valid = 1
//   in_valid  : current sel/in_bus pair is a real request
//   stall     : freeze the whole pipeline
//   out       : selected data, STAGES cycles after acceptance
//   out_valid : out carries a valid result
//   out_sel   : effective select that produced the word on out
//   sel_err   : the word on out came from an out-of-range select
//   err_count : saturating count of accepted out-of-range requests
// The master drives requests; the slave (the selector) drives results.
interface mux_sel_pipe_if #(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 6,
    parameter int SEL_W    = 3,
    parameter int ERRCNT_W = 8
);
    logic [N_INPUTS*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      stall;
    logic [WIDTH-1:0]          out;
    logic                      out_valid;
    logic [SEL_W-1:0]          out_sel;
    logic                      sel_err;
    logic [ERRCNT_W-1:0]       err_count;

    modport master (
        output in_bus, sel, in_valid, stall,
        input  out, out_valid, out_sel, sel_err, err_count
    );

    modport slave (
        input  in_bus, sel, in_valid, stall,
        output out, out_valid, out_sel, sel_err, err_count
    );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-input WIDTH-bit selector followed by a STAGES-deep register
// pipeline carrying data, effective select tag, out-of-range flag and valid.
// Out-of-range selects fall back to the last input and are flagged and counted.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (overrides stall)
//   bus   : mux_sel_pipe_if slave (requests in, pipelined results out)
// All outputs come straight from registers.
module mux_sel_pipe #(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 6,
    parameter int SEL_W    = 3,
    parameter int STAGES   = 1,
    parameter int ERRCNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mux_sel_pipe_if.slave bus
);
    // Slot table is padded to 2^SEL_W so any decoded select indexes in range.
    localparam int N_SLOTS = 2 ** SEL_W;

    logic [WIDTH-1:0]    in_arr_s [N_SLOTS];
    logic [SEL_W-1:0]    dec_sel_s;
    logic                dec_err_s;
    logic [WIDTH-1:0]    dec_data_s;

    logic [WIDTH-1:0]    data_r [STAGES];
    logic [SEL_W-1:0]    sel_r  [STAGES];
    logic [STAGES-1:0]   vld_r;
    logic [STAGES-1:0]   err_r;
    logic [ERRCNT_W-1:0] err_cnt_r;

    genvar k;
    generate
        for (k = 0; k < N_SLOTS; k++) begin : g_slot
            if (k < N_INPUTS) begin : g_used
                assign in_arr_s[k] = bus.in_bus[k*WIDTH +: WIDTH];
            end else begin : g_unused
                assign in_arr_s[k] = {WIDTH{1'b0}};
            end
        end
    endgenerate

    // Select decode: out-of-range falls back to the last input and raises the error bit.
    always_comb begin
        dec_sel_s = bus.sel;
        dec_err_s = 1'b0;
        // Widened compare so N_INPUTS == 2^SEL_W does not truncate to zero.
        if ({1'b0, bus.sel} >= (SEL_W+1)'(N_INPUTS)) begin
            dec_sel_s = SEL_W'(N_INPUTS - 1);
            dec_err_s = 1'b1;
        end else begin
            dec_sel_s = bus.sel;
            dec_err_s = 1'b0;
        end
        dec_data_s = in_arr_s[dec_sel_s];
    end

    // Pipeline stages: valid shifts every unstalled edge; payload loads only behind a valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= {STAGES{1'b0}};
            err_r <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                data_r[s] <= {WIDTH{1'b0}};
                sel_r[s]  <= {SEL_W{1'b0}};
            end
        end else if (!bus.stall) begin
            vld_r[0] <= bus.in_valid;
            if (bus.in_valid) begin
                data_r[0] <= dec_data_s;
                sel_r[0]  <= dec_sel_s;
                err_r[0]  <= dec_err_s;
            end
            for (int s = 1; s < STAGES; s++) begin
                vld_r[s] <= vld_r[s-1];
                if (vld_r[s-1]) begin
                    data_r[s] <= data_r[s-1];
                    sel_r[s]  <= sel_r[s-1];
                    err_r[s]  <= err_r[s-1];
                end
            end
        end
    end

    // Error counter: counts out-of-range requests at acceptance, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if (!bus.stall && bus.in_valid && dec_err_s &&
                     (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
        end
    end

    assign bus.out       = data_r[STAGES-1];
    assign bus.out_valid = vld_r[STAGES-1];
    assign bus.out_sel   = sel_r[STAGES-1];
    assign bus.sel_err   = err_r[STAGES-1];
    assign bus.err_count = err_cnt_r;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed bench for mux_sel_pipe across several pipeline
// depths (1, 2, 3, 4) and a 2-bit error counter. One instance per scenario,
// shared clock and reset, expectations hand-computed in the steps below.
module tb_mux_sel_pipe;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mux_sel_pipe_if #(.ERRCNT_W(2)) i1 ();
    mux_sel_pipe_if                 i2 ();
    mux_sel_pipe_if                 i3 ();
    mux_sel_pipe_if                 i4 ();

    mux_sel_pipe #(.STAGES(1), .ERRCNT_W(2)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    mux_sel_pipe #(.STAGES(2))               u2 (.clk(clk), .reset(reset), .bus(i2.slave));
    mux_sel_pipe #(.STAGES(3))               u3 (.clk(clk), .reset(reset), .bus(i3.slave));
    mux_sel_pipe #(.STAGES(4))               u4 (.clk(clk), .reset(reset), .bus(i4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input k = {hi, 16'hk}
    function automatic logic [6*32-1:0] pat(input logic [15:0] hi);
        logic [6*32-1:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = {hi, 16'(k)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        i1.in_bus = '0; i1.sel = '0; i1.in_valid = 1'b0; i1.stall = 1'b0;
        i2.in_bus = '0; i2.sel = '0; i2.in_valid = 1'b0; i2.stall = 1'b0;
        i3.in_bus = '0; i3.sel = '0; i3.in_valid = 1'b0; i3.stall = 1'b0;
        i4.in_bus = '0; i4.sel = '0; i4.in_valid = 1'b0; i4.stall = 1'b0;
        tick();
        tick();
        chk("rst_out",    64'(i1.out),       64'h0);
        chk("rst_valid",  64'(i1.out_valid), 64'h0);
        chk("rst_sel",    64'(i1.out_sel),   64'h0);
        chk("rst_err",    64'(i1.sel_err),   64'h0);
        chk("rst_cnt",    64'(i1.err_count), 64'h0);
        chk("rst_valid4", 64'(i4.out_valid), 64'h0);
        reset = 1'b0;

        // ---- STAGES=1 basic ----
        i1.in_bus = pat(16'hCAFE); i1.sel = 3'd2; i1.in_valid = 1'b1;
        tick();
        chk("basic_out",   64'(i1.out),       64'hCAFE0002);
        chk("basic_valid", 64'(i1.out_valid), 64'h1);
        chk("basic_sel",   64'(i1.out_sel),   64'h2);
        chk("basic_err",   64'(i1.sel_err),   64'h0);
        i1.in_valid = 1'b0;
        tick();
        chk("bubble_valid", 64'(i1.out_valid), 64'h0);
        chk("bubble_hold",  64'(i1.out),       64'hCAFE0002);

        // ---- out-of-range and saturation (ERRCNT_W=2) ----
        i1.in_bus = pat(16'hDEAD); i1.sel = 3'b110; i1.in_valid = 1'b1;
        tick();
        chk("oob6_out", 64'(i1.out),       64'hDEAD0005);
        chk("oob6_sel", 64'(i1.out_sel),   64'h5);
        chk("oob6_err", 64'(i1.sel_err),   64'h1);
        chk("sat_1",    64'(i1.err_count), 64'h1);
        i1.sel = 3'b111; i1.stall = 1'b1;
        tick();
        chk("stall_cnt_hold", 64'(i1.err_count), 64'h1);
        chk("stall_valid",    64'(i1.out_valid), 64'h1);
        i1.stall = 1'b0;
        tick();
        chk("oob7_out", 64'(i1.out),       64'hDEAD0005);
        chk("oob7_sel", 64'(i1.out_sel),   64'h5);
        chk("oob7_err", 64'(i1.sel_err),   64'h1);
        chk("sat_2",    64'(i1.err_count), 64'h2);
        tick();
        chk("sat_3", 64'(i1.err_count), 64'h3);
        i1.sel = 3'b110;
        tick();
        chk("sat_4", 64'(i1.err_count), 64'h3);
        i1.sel = 3'b111;
        tick();
        chk("sat_5", 64'(i1.err_count), 64'h3);
        i1.sel = 3'd4;
        tick();
        chk("inrange_out", 64'(i1.out),       64'hDEAD0004);
        chk("inrange_sel", 64'(i1.out_sel),   64'h4);
        chk("inrange_err", 64'(i1.sel_err),   64'h0);
        chk("inrange_cnt", 64'(i1.err_count), 64'h3);
        i1.in_valid = 1'b0;

        // ---- STAGES=3 streaming sel 0..5 ----
        i3.in_bus = pat(16'h1000);
        for (int t = 1; t <= 9; t++) begin
            i3.in_valid = (t <= 6);
            i3.sel      = 3'(t - 1);
            tick();
            chk($sformatf("stream_valid_t%0d", t), 64'(i3.out_valid),
                ((t >= 3) && (t <= 8)) ? 64'h1 : 64'h0);
            if ((t >= 3) && (t <= 8)) begin
                chk($sformatf("stream_out_t%0d", t), 64'(i3.out), 64'h10000000 + 64'(t - 3));
                chk($sformatf("stream_sel_t%0d", t), 64'(i3.out_sel), 64'(t - 3));
            end
        end
        chk("stream_hold", 64'(i3.out), 64'h10000005);

        // ---- STAGES=2 stall and bubble ----
        i2.in_bus = pat(16'h1000);
        i2.sel = 3'd1; i2.in_valid = 1'b1;
        tick();
        chk("stl_e1_valid", 64'(i2.out_valid), 64'h0);
        i2.sel = 3'd3; i2.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stl_hold_valid_%0d", c), 64'(i2.out_valid), 64'h0);
        end
        i2.stall = 1'b0;
        tick();
        chk("stl_a_valid", 64'(i2.out_valid), 64'h1);
        chk("stl_a_out",   64'(i2.out),       64'h10000001);
        chk("stl_a_sel",   64'(i2.out_sel),   64'h1);
        i2.in_valid = 1'b0;
        tick();
        chk("stl_b_valid", 64'(i2.out_valid), 64'h1);
        chk("stl_b_out",   64'(i2.out),       64'h10000003);
        tick();
        chk("stl_end_valid", 64'(i2.out_valid), 64'h0);
        chk("stl_end_hold",  64'(i2.out),       64'h10000003);

        // ---- STAGES=4 reset mid-flight ----
        i4.in_bus = pat(16'h1000);
        i4.sel = 3'd4; i4.in_valid = 1'b1;
        tick();
        i4.sel = 3'd7;
        tick();
        chk("mid_cnt_before", 64'(i4.err_count), 64'h1);
        i4.in_valid = 1'b0; i4.stall = 1'b1; reset = 1'b1;
        tick();
        chk("mid_out",   64'(i4.out),       64'h0);
        chk("mid_valid", 64'(i4.out_valid), 64'h0);
        chk("mid_sel",   64'(i4.out_sel),   64'h0);
        chk("mid_err",   64'(i4.sel_err),   64'h0);
        chk("mid_cnt",   64'(i4.err_count), 64'h0);
        chk("mid_cnt_u1", 64'(i1.err_count), 64'h0);
        reset = 1'b0; i4.stall = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("mid_gone_valid_%0d", c), 64'(i4.out_valid), 64'h0);
            chk($sformatf("mid_gone_out_%0d", c),   64'(i4.out),       64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered pipeline of STAGES stages, valid tagging and a global stall.
- Generalises the 3-bit-select 32-bit memory-read-control multiplexer used in the datapath, for paths that need timing closure or an aligned valid.
- Adds out-of-range select detection, a select tag travelling with the data, and a saturating error counter.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_INPUTS, 6, number of data inputs (2..16).
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_INPUTS.
- STAGES, 1, pipeline depth (1..4).
- ERRCNT_W, 8, width of the saturating out-of-range counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  N_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select, sampled with in_valid.
- in_valid  input  1  the current sel/in_bus pair is a real request.
- stall  input  1  freeze the whole pipeline.
- out  output  WIDTH  selected data after STAGES cycles.
- out_valid  output  1  out carries a valid result.
- out_sel  output  SEL_W  effective select used for the word on out.
- sel_err  output  1  the word on out came from an out-of-range select.
- err_count  output  ERRCNT_W  count of accepted out-of-range requests, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: all stage data, select and error registers go to 0. out = 0, out_valid = 0, out_sel = 0, sel_err = 0, err_count = 0. Reset overrides stall.
- Select decode (combinational, before stage 1):
  - If sel < N_INPUTS, the effective select is sel.
  - If sel >= N_INPUTS, the effective select is N_INPUTS-1 (last input, matching the legacy default-branch behaviour) and the error bit is 1.
- Advance: when stall = 0, every stage s loads from stage s-1. Stage 1 loads from the decode. When stall = 1, every register holds, including err_count.
- Valid bits shift unconditionally when stall = 0, so bubbles propagate as valid = 0.
- Data, select tag and error fields of a stage load only when the incoming valid is 1. A bubble leaves them unchanged, so out holds the last valid word while out_valid = 0.
- Latency: exactly STAGES clk edges with stall = 0 from in_valid = 1 to out_valid = 1. Throughput is one word per cycle.
- Each stall cycle adds exactly one cycle of latency. No word is dropped or duplicated.
- err_count increments by 1 on each edge where stall = 0, in_valid = 1 and sel >= N_INPUTS. It saturates at 2^ERRCNT_W-1 and never wraps.
  - It counts at acceptance (stage 1), not at output.
- Simultaneous events:
  - stall = 1 with in_valid = 1: the request is not accepted and the source must hold it.
  - reset = 1 with any other input: reset wins.
- Reset mid-operation: all in-flight words are discarded. out_valid is 0 from the next edge until a new request completes STAGES cycles later.
- No combinational path from any input to any output.

Test Plan:
- Reset/basic, STAGES=1: reset 2 cycles, then in_valid=1, sel=2, input2=32'hCAFE0002 -> next edge out=32'hCAFE0002, out_valid=1, out_sel=2, sel_err=0.
- Streaming, STAGES=3: sel=0..5 on consecutive cycles with input k=32'h1000_000k -> out_valid rises 3 cycles later; out sequence 0x10000000..0x10000005 on back-to-back cycles.
- Out-of-range: sel=3'b110 then 3'b111, input5=32'hDEAD0005 -> both outputs 32'hDEAD0005, out_sel=5, sel_err=1; err_count=2.
- Stall and bubble, STAGES=2: words A, B accepted; stall=1 for 3 cycles, then in_valid=0 -> A emerges 3 cycles later than nominal, then B; then out_valid=0 while out holds B.
- Saturation, ERRCNT_W=2: 5 out-of-range requests -> err_count sequence 1, 2, 3, 3, 3.
- Reset mid-flight, STAGES=4: 2 words in flight, reset=1 with stall=1 -> next edge all outputs 0; neither word ever appears.
